// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: control-bit positions
// and the access FSM state type.
package mem_stage_pkg;

  localparam int unsigned MEM_BRANCH  = 2;
  localparam int unsigned MEM_READ    = 1;
  localparam int unsigned MEM_WRITE   = 0;

  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/data_mem.sv
// Single-port word-addressed data memory: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module data_mem #(
  parameter int unsigned DEPTH_WORDS = 128
) (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: wait-stated data-memory access, upstream stall,
// branch resolution and the MEM/WB register.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic [1:0]  WB_i,
  input  logic [2:0]  Mem_i,
  input  logic        zero_i,
  input  logic [31:0] alu_ans_i,
  input  logic [31:0] rtdata_i,
  input  logic [4:0]  WBreg_i,
  input  logic [31:0] pc_add4_i,
  output logic        stall_o,
  output logic        branch_taken_o,
  output logic        misaligned_o,
  output logic [31:0] instr_o,
  output logic [1:0]  WB_o,
  output logic [31:0] alu_ans_o,
  output logic [4:0]  WBreg_o,
  output logic [31:0] pc_add4_o,
  output logic [31:0] rdata_o
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic        HAS_WAIT  = (WAIT_CYCLES != 0);
  localparam logic [2:0]  WAIT_LAST = 3'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        req_s, mis_s, acc_s, store_s, load_s;
  logic        stall_s, retire_s, we_s;
  logic [AW-1:0] idx_s;
  logic [31:0] mem_rdata_s;

  logic [31:0] instr_q, alu_ans_q, pc_add4_q, rdata_q;
  logic [1:0]  wb_q;
  logic [4:0]  wbreg_q;
  logic        mis_q;

  assign req_s   = Mem_i[MEM_READ] | Mem_i[MEM_WRITE];
  assign mis_s   = (alu_ans_i[1:0] != 2'b00);
  assign acc_s   = req_s & ~mis_s;
  assign store_s = Mem_i[MEM_WRITE];
  assign load_s  = Mem_i[MEM_READ] & ~Mem_i[MEM_WRITE];
  assign idx_s   = alu_ans_i[AW+1:2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_s  = 1'b0;
    retire_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc_s && HAS_WAIT) begin
          stall_s = 1'b1;
          state_d = BUSY;
          cnt_d   = WAIT_LAST;
        end else begin
          retire_s = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q != 3'd0) begin
          stall_s = 1'b1;
          cnt_d   = cnt_q - 3'd1;
        end else begin
          retire_s = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Gating with reset keeps combinational outputs quiet and blocks a held store while reset is low.
  assign we_s           = retire_s & acc_s & store_s & rst_i;
  assign stall_o        = stall_s & rst_i;
  assign branch_taken_o = Mem_i[MEM_BRANCH] & zero_i & retire_s & rst_i;

  data_mem #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_data_mem (
    .clk_i  (clk_i),
    .we_i   (we_s),
    .addr_i (idx_s),
    .wdata_i(rtdata_i),
    .rdata_o(mem_rdata_s)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      instr_q   <= 32'd0;
      wb_q      <= 2'b00;
      alu_ans_q <= 32'd0;
      wbreg_q   <= 5'd0;
      pc_add4_q <= 32'd0;
      rdata_q   <= 32'd0;
      mis_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (retire_s) begin
        instr_q   <= instr_i;
        wb_q      <= (req_s & mis_s) ? 2'b00 : WB_i;
        alu_ans_q <= alu_ans_i;
        wbreg_q   <= WBreg_i;
        pc_add4_q <= pc_add4_i;
        rdata_q   <= (acc_s & load_s) ? mem_rdata_s : 32'd0;
        mis_q     <= req_s & mis_s;
      end else begin
        instr_q   <= 32'd0;
        wb_q      <= 2'b00;
        alu_ans_q <= 32'd0;
        wbreg_q   <= 5'd0;
        pc_add4_q <= 32'd0;
        rdata_q   <= 32'd0;
        mis_q     <= 1'b0;
      end
    end
  end

  assign instr_o      = instr_q;
  assign WB_o         = wb_q;
  assign alu_ans_o    = alu_ans_q;
  assign WBreg_o      = wbreg_q;
  assign pc_add4_o    = pc_add4_q;
  assign rdata_o      = rdata_q;
  assign misaligned_o = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench: one stage with two wait states, one with none,
// each checked against a per-instruction occupancy/result model.
module tb_mem_access_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] instr_v [2];
  logic [1:0]  wb_v    [2];
  logic [2:0]  mem_v   [2];
  logic        zero_v  [2];
  logic [31:0] alu_v   [2];
  logic [31:0] rt_v    [2];
  logic [4:0]  wbreg_v [2];
  logic [31:0] pc_v    [2];

  logic        stall_o_v [2];
  logic        br_o_v    [2];
  logic        mis_o_v   [2];
  logic [31:0] instr_o_v [2];
  logic [1:0]  wb_o_v    [2];
  logic [31:0] alu_o_v   [2];
  logic [4:0]  wbreg_o_v [2];
  logic [31:0] pc_o_v    [2];
  logic [31:0] rdata_o_v [2];

  mem_access_stage #(.DEPTH_WORDS(128), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk_i(clk), .rst_i(rst_n),
    .instr_i(instr_v[0]), .WB_i(wb_v[0]), .Mem_i(mem_v[0]), .zero_i(zero_v[0]),
    .alu_ans_i(alu_v[0]), .rtdata_i(rt_v[0]), .WBreg_i(wbreg_v[0]), .pc_add4_i(pc_v[0]),
    .stall_o(stall_o_v[0]), .branch_taken_o(br_o_v[0]), .misaligned_o(mis_o_v[0]),
    .instr_o(instr_o_v[0]), .WB_o(wb_o_v[0]), .alu_ans_o(alu_o_v[0]),
    .WBreg_o(wbreg_o_v[0]), .pc_add4_o(pc_o_v[0]), .rdata_o(rdata_o_v[0])
  );

  mem_access_stage #(.DEPTH_WORDS(128), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk_i(clk), .rst_i(rst_n),
    .instr_i(instr_v[1]), .WB_i(wb_v[1]), .Mem_i(mem_v[1]), .zero_i(zero_v[1]),
    .alu_ans_i(alu_v[1]), .rtdata_i(rt_v[1]), .WBreg_i(wbreg_v[1]), .pc_add4_i(pc_v[1]),
    .stall_o(stall_o_v[1]), .branch_taken_o(br_o_v[1]), .misaligned_o(mis_o_v[1]),
    .instr_o(instr_o_v[1]), .WB_o(wb_o_v[1]), .alu_ans_o(alu_o_v[1]),
    .WBreg_o(wbreg_o_v[1]), .pc_add4_o(pc_o_v[1]), .rdata_o(rdata_o_v[1])
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem   [2][128];
  bit          model_valid [2][128];

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic [31:0] ins, input logic [1:0] wb,
                       input logic [2:0] mc, input logic z, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [4:0] wr, input logic [31:0] pc);
    instr_v[d] = ins; wb_v[d] = wb; mem_v[d] = mc; zero_v[d] = z;
    alu_v[d] = alu; rt_v[d] = rt; wbreg_v[d] = wr; pc_v[d] = pc;
  endtask

  // Issue one instruction and check it cycle by cycle until it retires.
  task automatic issue(input int d, input logic [31:0] ins, input logic [1:0] wb,
                       input logic [2:0] mc, input logic z, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [4:0] wr, input logic [31:0] pc);
    bit          req, mis, acc, st, ld;
    int          occ, idx;
    logic [31:0] exp_rd;
    req    = mc[1] | mc[0];
    mis    = (alu[1:0] != 2'b00);
    acc    = req && !mis;
    st     = mc[0];
    ld     = mc[1] && !mc[0];
    occ    = acc ? wait_of(d) + 1 : 1;
    idx    = int'(alu[8:2]);
    exp_rd = (acc && ld) ? model_mem[d][idx] : 32'd0;
    for (int c = 0; c < occ; c++) begin
      @(negedge clk);
      if (c == 0) drive(d, ins, wb, mc, z, alu, rt, wr, pc);
      #1;
      check("stall", {31'd0, stall_o_v[d]}, {31'd0, (c < occ - 1)});
      check("branch_taken", {31'd0, br_o_v[d]}, {31'd0, (mc[2] && z && c == occ - 1)});
      @(posedge clk);
      #1;
      if (c < occ - 1) begin
        check("bubble_instr", instr_o_v[d], 32'd0);
        check("bubble_wb", {30'd0, wb_o_v[d]}, 32'd0);
        check("bubble_rdata", rdata_o_v[d], 32'd0);
        check("bubble_mis", {31'd0, mis_o_v[d]}, 32'd0);
      end else begin
        check("instr_o", instr_o_v[d], ins);
        check("wb_o", {30'd0, wb_o_v[d]}, {30'd0, (req && mis) ? 2'b00 : wb});
        check("alu_ans_o", alu_o_v[d], alu);
        check("wbreg_o", {27'd0, wbreg_o_v[d]}, {27'd0, wr});
        check("pc_add4_o", pc_o_v[d], pc);
        check("rdata_o", rdata_o_v[d], exp_rd);
        check("misaligned_o", {31'd0, mis_o_v[d]}, {31'd0, (req && mis)});
      end
    end
    if (acc && st) begin
      model_mem[d][idx]   = rt;
      model_valid[d][idx] = 1'b1;
    end
  endtask

  task automatic random_instr(input int d);
    logic [31:0] alu;
    logic [2:0]  mc;
    int          word, t;
    word = $urandom_range(0, 7);
    alu  = ($urandom() & 32'hFFFF_FE00) | (32'(word) << 2);
    t    = $urandom_range(0, 4);
    case (t)
      0: mc = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b011;
      1: mc = model_valid[d][word] ? 3'b010 : 3'b001;
      2: begin
        alu[1:0] = 2'($urandom_range(1, 3));
        mc       = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b001;
      end
      3: mc = 3'b100;
      default: mc = 3'b000;
    endcase
    issue(d, $urandom(), 2'($urandom()), mc, 1'($urandom()), alu, $urandom(),
          5'($urandom()), $urandom());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      drive(d, 32'd0, 2'b00, 3'b000, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
      for (int i = 0; i < 128; i++) model_valid[d][i] = 1'b0;
    end
    rst_n = 1'b0;
    #12;
    for (int d = 0; d < 2; d++) begin
      check("reset_stall", {31'd0, stall_o_v[d]}, 32'd0);
      check("reset_instr", instr_o_v[d], 32'd0);
      check("reset_rdata", rdata_o_v[d], 32'd0);
      check("reset_mis", {31'd0, mis_o_v[d]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Two-wait-state stage: directed sequence.
    issue(0, 32'hAC00_0010, 2'b00, 3'b001, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 32'h0000_0104);
    issue(0, 32'h8C05_0010, 2'b11, 3'b010, 1'b0, 32'h0000_0010, 32'h0,        5'd5, 32'h0000_0108);
    check("plan_load_data", rdata_o_v[0], 32'hDEAD_BEEF);
    issue(0, 32'h8C06_0006, 2'b11, 3'b010, 1'b0, 32'h0000_0006, 32'h0,        5'd6, 32'h0000_010C);
    issue(0, 32'h0000_0020, 2'b10, 3'b000, 1'b0, 32'h0000_0006, 32'h0,        5'd7, 32'h0000_0110);
    issue(0, 32'h1000_0004, 2'b00, 3'b100, 1'b1, 32'h0000_0000, 32'h0,        5'd0, 32'h0000_0114);
    issue(0, 32'h1000_0008, 2'b00, 3'b100, 1'b0, 32'h0000_0001, 32'h0,        5'd0, 32'h0000_0118);
    issue(0, 32'hAC00_0020, 2'b00, 3'b001, 1'b0, 32'h0000_0020, 32'h1111_1111, 5'd0, 32'h0000_011C);

    // Reset mid-access on a store to 0x20 must abort it.
    @(negedge clk);
    drive(0, 32'hAC00_0020, 2'b00, 3'b001, 1'b0, 32'h0000_0020, 32'hBADB_AD00, 5'd0, 32'h0000_0120);
    #1;
    check("rst_pre_stall", {31'd0, stall_o_v[0]}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_stall", {31'd0, stall_o_v[0]}, 32'd0);
    check("rst_instr", instr_o_v[0], 32'd0);
    check("rst_pc", pc_o_v[0], 32'd0);
    check("rst_branch", {31'd0, br_o_v[0]}, 32'd0);
    @(negedge clk);
    drive(0, 32'd0, 2'b00, 3'b000, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
    rst_n = 1'b1;
    issue(0, 32'h0000_0033, 2'b10, 3'b000, 1'b0, 32'h0000_0040, 32'h0, 5'd3, 32'h0000_0200);
    issue(0, 32'h8C08_0020, 2'b11, 3'b010, 1'b0, 32'h0000_0020, 32'h0, 5'd8, 32'h0000_0204);
    check("rst_aborted_store", rdata_o_v[0], 32'h1111_1111);

    for (int n = 0; n < 40; n++) random_instr(0);
    @(negedge clk);
    drive(0, 32'd0, 2'b00, 3'b000, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0);

    // Zero-wait-state stage: aliasing at the top word, then random traffic.
    issue(1, 32'hAC00_01FC, 2'b00, 3'b001, 1'b0, 32'h0000_01FC, 32'hA5A5_0001, 5'd0, 32'h0000_0300);
    issue(1, 32'h8C01_03FC, 2'b11, 3'b010, 1'b0, 32'h0000_03FC, 32'h0,        5'd1, 32'h0000_0304);
    check("alias_load_a", rdata_o_v[1], 32'hA5A5_0001);
    issue(1, 32'hAC00_03FC, 2'b00, 3'b011, 1'b0, 32'h0000_03FC, 32'h5A5A_0002, 5'd0, 32'h0000_0308);
    issue(1, 32'h8C02_01FC, 2'b11, 3'b010, 1'b0, 32'h0000_01FC, 32'h0,        5'd2, 32'h0000_030C);
    check("alias_load_b", rdata_o_v[1], 32'h5A5A_0002);

    for (int n = 0; n < 20; n++) random_instr(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
